// File: rtl/bounce_engine.sv
// bounce_engine: frame-synchronous position update for OBJ_CNT squares reflecting off screen edges
module bounce_engine #(
  parameter int CORDW     = 12,
  parameter int H_RES     = 1280,
  parameter int V_RES     = 720,
  parameter int Q_SIZE    = 200,
  parameter int OBJ_CNT   = 4,
  parameter int FRAME_NUM = 1,
  parameter int X_STEP    = 64,
  parameter int Y_STEP    = 32
) (
  input  logic                     clk_pix,
  input  logic                     rst_pix_n,
  input  logic                     frame,
  input  logic                     en,
  input  logic [CORDW-1:0]         speed,
  output logic [OBJ_CNT*CORDW-1:0] qx,
  output logic [OBJ_CNT*CORDW-1:0] qy,
  output logic [OBJ_CNT-1:0]       qdx,
  output logic [OBJ_CNT-1:0]       qdy,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam int W  = CORDW + 2;
  localparam int IW = OBJ_CNT > 1 ? $clog2(OBJ_CNT) : 1;
  localparam int FW = FRAME_NUM > 1 ? $clog2(FRAME_NUM) : 1;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t                         r_state, w_next;
  logic [OBJ_CNT-1:0][CORDW-1:0]  r_qx, r_qy;
  logic [OBJ_CNT-1:0]             r_qdx, r_qdy;
  logic [CORDW-1:0]               r_spd;
  logic [IW-1:0]                  r_idx;
  logic [FW-1:0]                  r_cnt;
  logic                           r_overrun;
  logic                           w_trig, w_last, w_ndx, w_ndy;
  logic [CORDW-1:0]               w_nx, w_ny;
  // returns {new_dir, new_pos}; sums are widened so large speeds never wrap
  function automatic logic [CORDW:0] step(input logic [CORDW-1:0] p, input logic d,
                                          input logic [CORDW-1:0] s, input int res);
    return d ? ((W'(p) < W'(s)) ? {1'b0, CORDW'(0)} : {1'b1, p - s})
             : ((W'(p) + W'(Q_SIZE) + W'(s) >= W'(res - 1)) ? {1'b1, CORDW'(res - Q_SIZE - 1)}
                                                            : {1'b0, p + s});
  endfunction
  assign {w_ndx, w_nx} = step(r_qx[r_idx], r_qdx[r_idx], r_spd, H_RES);
  assign {w_ndy, w_ny} = step(r_qy[r_idx], r_qdy[r_idx], r_spd, V_RES);
  assign w_trig  = frame && en && r_cnt == '0;
  assign w_last  = r_idx == IW'(OBJ_CNT - 1);
  assign qx      = r_qx;
  assign qy      = r_qy;
  assign qdx     = r_qdx;
  assign qdy     = r_qdy;
  assign busy    = r_state == UPDATE;
  assign done    = r_state == DONE;
  assign overrun = r_overrun;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE && w_trig) w_next = UPDATE;
    if (r_state == UPDATE) w_next = w_last ? DONE : UPDATE;
  end
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_state   <= IDLE;
      r_spd     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < OBJ_CNT; i++) begin
        r_qx[i]  <= CORDW'(i * X_STEP);
        r_qy[i]  <= CORDW'(i * Y_STEP);
        r_qdx[i] <= i[0];
        r_qdy[i] <= 1'b0;
      end
    end else begin
      r_state   <= w_next;
      r_overrun <= w_trig && r_state != IDLE;
      if (frame && en) r_cnt <= (r_cnt == FW'(FRAME_NUM - 1)) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && w_trig) begin
        r_spd <= speed;
        r_idx <= '0;
      end
      if (r_state == UPDATE) begin
        r_idx        <= w_last ? '0 : r_idx + 1'b1;
        r_qx[r_idx]  <= w_nx;
        r_qy[r_idx]  <= w_ny;
        r_qdx[r_idx] <= w_ndx;
        r_qdy[r_idx] <= w_ndy;
      end
    end
  end
endmodule

// File: doc/bounce_engine.md
# bounce_engine

Frame-synchronous motion engine for up to `OBJ_CNT` bouncing squares. Once every `FRAME_NUM` frames it walks all objects sequentially, advancing each by the sampled speed and reflecting off the screen edges. It sits upstream of the paint/compare logic, which consumes the flattened position vectors, and downstream of the display timing generator, which supplies the `frame` pulse. It runs entirely in the pixel clock domain.

## Interface
Parameters:
- `CORDW`, default 12: coordinate width in bits.
- `H_RES`, default 1280: horizontal resolution in pixels.
- `V_RES`, default 720: vertical resolution in pixels.
- `Q_SIZE`, default 200: square edge length in pixels.
- `OBJ_CNT`, default 4: number of objects, range 1..16.
- `FRAME_NUM`, default 1: update every N frames, N ≥ 1.
- `X_STEP`, default 64: reset x spacing. Requires `(OBJ_CNT-1)*X_STEP + Q_SIZE < H_RES`.
- `Y_STEP`, default 32: reset y spacing. Requires `(OBJ_CNT-1)*Y_STEP + Q_SIZE < V_RES`.

Ports:
- `clk_pix`  in  1  pixel clock.
- `rst_pix_n`  in  1  reset. Synchronous, active-low.
- `frame`  in  1  one-cycle pulse at start of vertical blanking.
- `en`  in  1  run enable. When low, frames are neither counted nor acted on.
- `speed`  in  CORDW  pixels per update. Sampled on the trigger cycle.
- `qx`  out  OBJ_CNT*CORDW  x positions. Object i occupies bits `[i*CORDW +: CORDW]`.
- `qy`  out  OBJ_CNT*CORDW  y positions, same packing as `qx`.
- `qdx`  out  OBJ_CNT  x direction per object: 0 = right, 1 = left.
- `qdy`  out  OBJ_CNT  y direction per object: 0 = down, 1 = up.
- `busy`  out  1  high while objects are being updated.
- `done`  out  1  one-cycle pulse when an update pass completes.
- `overrun`  out  1  one-cycle pulse when a trigger is dropped.

## Operation
- **Reset** (applies to every output and internal register):
  - `qx[i]=i*X_STEP`, `qy[i]=i*Y_STEP`.
  - `qdx[i]=i[0]`, `qdy[i]=0`.
  - `busy=0`, `done=0`, `overrun=0`.
  - `cnt_frame=0`, FSM in IDLE, `spd=0`, `idx=0`.
- **Frame divider:**
  - On `frame && en`, `cnt_frame` advances 0→1→…→`FRAME_NUM-1`→0.
  - The divider also advances while `busy`.
- **Trigger:** `frame && en && cnt_frame==0`.
- **FSM states:** IDLE, UPDATE, DONE.
  - IDLE, on trigger: latch `spd<=speed`, `idx<=0`, go to UPDATE.
  - UPDATE: one object per cycle, at index `idx`. `idx` increments each cycle. After `idx==OBJ_CNT-1`, go to DONE.
  - DONE: `done=1` for one cycle, then go to IDLE.
- **Per-axis update rule** (x shown; y is identical with `V_RES`, `qy`, `qdy`):
  - Moving right (`qdx=0`):
    - If `qx+Q_SIZE+spd >= H_RES-1`: `qx<=H_RES-Q_SIZE-1`, `qdx<=1`.
    - Else: `qx<=qx+spd`.
  - Moving left (`qdx=1`):
    - If `qx < spd`: `qx<=0`, `qdx<=0`.
    - Else: `qx<=qx-spd`.
  - Arithmetic: comparisons are evaluated at CORDW+2 bits, with no wrap.
  - Any `speed` ≥ the screen extent snaps the object to an edge.
  - `spd=0`: objects not at an edge stay put.
  - An object exactly at the right/bottom snap point with `spd=0` still reflects, because `>=` holds.
- **Trigger while not IDLE:** dropped and `overrun` pulses. The in-progress pass is unaffected.
- **`en` deassert mid-pass:** the pass completes anyway. `en` gates triggers only.
- **`rst_pix_n` low mid-pass:** reset values load on that edge and the pass is abandoned. No `done` is issued.
- Positions not being updated hold their value. Only object `idx` changes in a given cycle.

## Timing
- Trigger sampled in cycle T.
- `busy=1` in cycles T+1 … T+OBJ_CNT.
- Object i's new value becomes visible from cycle T+2+i.
- `done=1` in cycle T+1+OBJ_CNT, with `busy=0` in that cycle.
- The next trigger is accepted from cycle T+2+OBJ_CNT.
- `overrun` is asserted the cycle after the dropped trigger.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Total pass latency is OBJ_CNT+1 cycles, far below the 720p vertical blank.

## Test plan
- **Reset:** hold `rst_pix_n=0` for 2 cycles with defaults, then release.
  - Required: qx={0,64,128,192}, qy={0,32,64,96}, qdx=4'b1010, qdy=0, busy/done/overrun=0.
- **Right-edge reflection:** OBJ_CNT=1, qx=1074, qdx=0, speed=2, four triggers.
  - Required: qx sequence 1076, 1078, 1079 (qdx→1), 1077.
- **Left/top reflection:** qx=1, qdx=1, qy=1, qdy=1, speed=2, one trigger.
  - Required: qx=0, qy=0, qdx=0, qdy=0.
- **Divider:** FRAME_NUM=3, en=1, seven frame pulses.
  - Required: updates (`done` pulses) on frames 1, 4, 7 only. With en=0, frames cause no update and `cnt_frame` holds.
- **Cycle timing and overrun:** OBJ_CNT=4, trigger at T, then a second `frame` pulse at T+2.
  - Required: busy high T+1..T+4, object 2 changes at T+4, done at T+5, overrun at T+3, no second pass.
- **Reset mid-pass:** assert `rst_pix_n=0` at T+2 of a pass.
  - Required: reset values at T+3, busy=0, and no `done` pulse.
